prbs_bit_source: RTL and testbench
==================================

Name: prbs_bit_source

Overview:
Serial pseudo-random bit generator for the Tx simulation chain. Its bit_out/bit_valid pair drives the data_in/data_in_valid inputs of the Gray/PAM4 symbol encoder directly downstream. The block provides PRBS7/15/23/31 patterns, a programmable bit rate (one bit every rate_div+1 clocks), software seeding and an emitted-bit counter for BER bookkeeping.

Parameters:
PRBS_ORDER, 7, LFSR length and polynomial select; legal values 7, 15, 23, 31 (others: elaboration error)
DEFAULT_SEED, all ones (PRBS_ORDER bits), LFSR value after reset
DIV_W, 16, width of rate_div and the pacing counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active-low
start  in  1  level-sampled; in IDLE, begins generation
stop  in  1  level-sampled; in RUN, returns to IDLE
rate_div  in  DIV_W  inter-bit spacing minus one; captured on start
seed_load  in  1  in IDLE, loads seed_in into the LFSR
seed_in  in  PRBS_ORDER  seed value
bit_out  out  1  generated bit; meaningful only while bit_valid=1
bit_valid  out  1  one-cycle qualifier per generated bit
busy  out  1  1 while in RUN
bit_count  out  32  bits emitted since the last start; saturates at 32'hFFFF_FFFF
seed_fixed  out  1  sticky; set when a zero seed was replaced by all ones; cleared on start

Behaviour:
- Reset (async): state=IDLE, lfsr=DEFAULT_SEED, bit_out=0, bit_valid=0, busy=0, bit_count=0, seed_fixed=0, pacing cnt=0, rate_q=0.
- LFSR, Fibonacci with N=PRBS_ORDER: fb = lfsr[N-1] ^ lfsr[T-1]; on advance, lfsr <= {lfsr[N-2:0], fb} and bit_out <= fb.
- Taps T: PRBS7 x^7+x^6+1 (T=6); PRBS15 x^15+x^14+1 (T=14); PRBS23 x^23+x^18+1 (T=18); PRBS31 x^31+x^28+1 (T=28).
- State machine, two states:
  - IDLE: seed_load=1 -> lfsr <= seed_in; if seed_in==0, load all ones and set seed_fixed instead.
  - IDLE: start=1 -> RUN; rate_q <= rate_div; cnt <= rate_div; bit_count <= 0; seed_fixed <= 0.
  - IDLE: start has priority over seed_load when both are asserted (seed ignored).
  - RUN, each edge:
    - stop=1 -> IDLE, bit_valid <= 0, no bit emitted on that edge.
    - else cnt==0 -> advance LFSR, bit_valid <= 1, cnt <= rate_q, bit_count++ (saturating).
    - else cnt--, bit_valid <= 0.
  - RUN: start and seed_load are ignored; rate_div changes take effect only on the next start.
- Latency: start sampled on edge E0 -> first bit_valid high in the cycle after edge E(rate_div+1). Pulses then repeat every rate_div+1 cycles. rate_div=0 gives bit_valid continuously high.
- LFSR state is retained across stop/start, so the sequence resumes seamlessly unless reseeded.
- busy is registered and equals (state==RUN).
- Reset mid-RUN: immediate return to the reset values above; any partial interval is discarded.
- Sequence period is 2^N-1. PRBS7 from all ones: first 8 bits 0,0,0,0,0,0,1,0; 64 ones and 63 zeros per period.

Optional Feature:
PRBS_ERR_INJ_EN
- Defined: adds input err_inject (1 bit) and output err_count (16 bit, saturating, reset 0, cleared on start).
  - An err_inject pulse arms a flag; the next emitted bit is inverted, and the flag and err_count update on that edge.
  - Multiple pulses before one emission count as a single error.
  - LFSR state is unaffected, so the downstream checker resyncs without a reseed.
- Undefined: neither port exists and bit_out is always the raw LFSR output.

Decomposition:
- Package prbs_pkg: tap constants per order (ORDER, TAP pairs), state encoding (ST_IDLE, ST_RUN), BIT_CNT_W=32.
- Sub-module prbs_lfsr_core (params N, T; ports clk, rstn, load, load_val, advance, fb_out, state_out) holds the LFSR and all-zero protection. The top level holds the FSM, pacing counter, counters and the optional injection logic.

Test Plan:
- PRBS7, reset seed, rate_div=0, start one cycle -> bit_valid continuous from E1; first 8 bits 00000010; 127-bit period repeats exactly; bit_count=127 after one period.
- rate_div=3, start -> bit_valid pulses exactly every 4 cycles, first pulse after E4; 10 pulses give bit_count=10.
- seed_load with seed_in=0 in IDLE -> seed_fixed=1, lfsr=all ones; then start -> seed_fixed=0 and sequence identical to the reset case.
- stop after 5 bits, then restart -> no bit_valid while IDLE; the 6th bit equals bit 6 of the uninterrupted sequence; start and seed_load together in IDLE -> seed ignored.
- rstn deasserted mid-RUN, rate_div=5 -> all outputs at reset values asynchronously; no bit_valid until a new start.
- PRBS_ERR_INJ_EN: err_inject at bit 10 -> bit 10 inverted, bit 11 correct, err_count=1; two pulses before one emission -> err_count=1.

Source files
------------

// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS bit source: supported LFSR orders and their
// feedback taps, FSM state encoding and the emitted-bit counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package prbs_pkg;

    localparam int BIT_CNT_W = 32;
    localparam int ERR_CNT_W = 16;

    // Supported orders and their second feedback tap (polynomial x^N + x^T + 1)
    localparam int ORDER_7  = 7;
    localparam int TAP_7    = 6;
    localparam int ORDER_15 = 15;
    localparam int TAP_15   = 14;
    localparam int ORDER_23 = 23;
    localparam int TAP_23   = 18;
    localparam int ORDER_31 = 31;
    localparam int TAP_31   = 28;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } prbs_state_e;

    // Returns the tap for a supported order, 0 for anything else.
    function automatic int prbs_tap(input int order);
        int tap;
        case (order)
            ORDER_7:  tap = TAP_7;
            ORDER_15: tap = TAP_15;
            ORDER_23: tap = TAP_23;
            ORDER_31: tap = TAP_31;
            default:  tap = 0;
        endcase
        return tap;
    endfunction

    function automatic bit prbs_order_ok(input int order);
        return prbs_tap(order) != 0;
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// ---------------------------------------------------------------------------
// prbs_lfsr_core
// Fibonacci LFSR of length N with feedback fb = q[N-1] ^ q[T-1]. An advance
// shifts fb into bit 0. A load replaces the register; an all-zero load value
// is replaced by all ones so the register can never lock up.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous reset, active-low (register <- INIT)
//   load       in   load load_val (has priority over advance)
//   load_val   in   N  value to load
//   advance    in   shift one step
//   fb_out     out  feedback bit, i.e. the bit produced by the next advance
//   state_out  out  N  current register contents
// ---------------------------------------------------------------------------
module prbs_lfsr_core #(
    parameter int             N    = 7,
    parameter int             T    = 6,
    parameter logic [N-1:0]   INIT = '1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         advance,
    output logic         fb_out,
    output logic [N-1:0] state_out
);

    logic [N-1:0] lfsr_q;
    logic [N-1:0] lfsr_d;
    logic         fb;

    assign fb = lfsr_q[N-1] ^ lfsr_q[T-1];

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (load_val == '0) ? '1 : load_val;
        end else if (advance) begin
            lfsr_d = {lfsr_q[N-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign fb_out    = fb;
    assign state_out = lfsr_q;

endmodule

// File: rtl/prbs_bit_source.sv
// ---------------------------------------------------------------------------
// prbs_bit_source
// Paced serial PRBS7/15/23/31 generator feeding the Gray/PAM4 symbol encoder.
// One bit is emitted every rate_div+1 clocks while running; the LFSR state is
// kept across stop/start so a stopped stream resumes where it left off.
//
// Optional build macro PRBS_ERR_INJ_EN adds single-bit error injection
// (err_inject input, err_count output). Without it bit_out is the raw LFSR bit.
//
// Ports:
//   clk         in   clock
//   rstn        in   asynchronous reset, active-low
//   start       in   IDLE: begin generation, capture rate_div
//   stop        in   RUN: return to IDLE (no bit on that edge)
//   rate_div    in   DIV_W  inter-bit spacing minus one
//   seed_load   in   IDLE: load seed_in into the LFSR
//   seed_in     in   PRBS_ORDER  seed value (zero is replaced by all ones)
//   bit_out     out  generated bit, valid with bit_valid
//   bit_valid   out  one-cycle qualifier per bit
//   busy        out  high while running
//   bit_count   out  32  bits since last start, saturating
//   seed_fixed  out  sticky zero-seed-replaced flag, cleared on start
//   err_inject  in   (PRBS_ERR_INJ_EN) invert the next emitted bit
//   err_count   out  16 (PRBS_ERR_INJ_EN) injected errors since start, saturating
// ---------------------------------------------------------------------------
module prbs_bit_source
    import prbs_pkg::*;
#(
    parameter int                      PRBS_ORDER   = 7,
    parameter logic [PRBS_ORDER-1:0]   DEFAULT_SEED = '1,
    parameter int                      DIV_W        = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DIV_W-1:0]       rate_div,
    input  logic                   seed_load,
    input  logic [PRBS_ORDER-1:0]  seed_in,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   busy,
    output logic [BIT_CNT_W-1:0]   bit_count,
    output logic                   seed_fixed
`ifdef PRBS_ERR_INJ_EN
    ,
    input  logic                   err_inject,
    output logic [ERR_CNT_W-1:0]   err_count
`endif
);

    localparam int TAP = prbs_tap(PRBS_ORDER);

    if (!prbs_order_ok(PRBS_ORDER)) begin : g_bad_order
        $error("prbs_bit_source: PRBS_ORDER must be 7, 15, 23 or 31");
    end

    prbs_state_e            state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       rate_q, rate_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   busy_q, busy_d;
    logic [BIT_CNT_W-1:0]   bit_count_q, bit_count_d;
    logic                   seed_fixed_q, seed_fixed_d;

    logic                   lfsr_load;
    logic                   lfsr_adv;
    logic                   lfsr_fb;
    logic [PRBS_ORDER-1:0]  lfsr_state_unused;

`ifdef PRBS_ERR_INJ_EN
    logic                   err_armed_q, err_armed_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
`endif

    prbs_lfsr_core #(
        .N    (PRBS_ORDER),
        .T    (TAP),
        .INIT (DEFAULT_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (lfsr_load),
        .load_val  (seed_in),
        .advance   (lfsr_adv),
        .fb_out    (lfsr_fb),
        .state_out (lfsr_state_unused)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        bit_count_d  = bit_count_q;
        seed_fixed_d = seed_fixed_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;
`ifdef PRBS_ERR_INJ_EN
        // A pulse arms the flag in any state; repeated pulses collapse into one.
        err_armed_d  = err_armed_q | err_inject;
        err_count_d  = err_count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    rate_d       = rate_div;
                    cnt_d        = rate_div;
                    bit_count_d  = '0;
                    seed_fixed_d = 1'b0;
`ifdef PRBS_ERR_INJ_EN
                    err_count_d  = '0;
`endif
                end else if (seed_load) begin
                    lfsr_load = 1'b1;
                    if (seed_in == '0) begin
                        seed_fixed_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    lfsr_adv    = 1'b1;
                    bit_valid_d = 1'b1;
                    bit_out_d   = lfsr_fb;
                    cnt_d       = rate_q;
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
`ifdef PRBS_ERR_INJ_EN
                    // Only the emitted bit is corrupted; the LFSR keeps running
                    // clean so the downstream checker can resync on its own.
                    if (err_armed_q) begin
                        bit_out_d   = ~lfsr_fb;
                        err_armed_d = err_inject;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rate_q       <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            bit_count_q  <= '0;
            seed_fixed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
            bit_count_q  <= bit_count_d;
            seed_fixed_q <= seed_fixed_d;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_armed_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_armed_q <= err_armed_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign bit_count  = bit_count_q;
    assign seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_prbs_bit_source.sv
// ---------------------------------------------------------------------------
// tb_prbs_bit_source
// Directed + randomized bench for prbs_bit_source (PRBS7). The reference
// model generates the sequence from the recurrence b[k] = b[k-N] ^ b[k-T]
// over a bit history and predicts bit timing from the phase since start.
// Build with +define+PRBS_ERR_INJ_EN to exercise error injection.
// ---------------------------------------------------------------------------
module tb_prbs_bit_source;

    localparam int N = 7;
    localparam int T = (N == 7) ? 6 : (N == 15) ? 14 : (N == 23) ? 18 : 28;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic [15:0]   rate_div  = '0;
    logic          seed_load = 1'b0;
    logic [N-1:0]  seed_in   = '0;
    logic          bit_out;
    logic          bit_valid;
    logic          busy;
    logic [31:0]   bit_count;
    logic          seed_fixed;
`ifdef PRBS_ERR_INJ_EN
    logic          err_inject = 1'b0;
    logic [15:0]   err_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit  mh[$];
    bit  m_run    = 0;
    int  m_k      = 0;
    int  m_r      = 0;
    int  m_count  = 0;
    bit  m_fixed  = 0;
    bit  m_armed  = 0;
    int  m_errs   = 0;
    bit  obs[$];

    prbs_bit_source #(.PRBS_ORDER(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .rate_div   (rate_div),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .bit_count  (bit_count),
        .seed_fixed (seed_fixed)
`ifdef PRBS_ERR_INJ_EN
        ,
        .err_inject (err_inject),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic model_seed(input logic [N-1:0] s);
        mh.delete();
        for (int i = N - 1; i >= 0; i--) mh.push_back((s == '0) ? 1'b1 : s[i]);
    endtask

    function automatic bit model_next();
        bit b;
        b = mh[0] ^ mh[N - T];
        mh.push_back(b);
        void'(mh.pop_front());
        return b;
    endfunction

    // Bit idx (0-based) of the uninterrupted sequence from seed s.
    function automatic bit ref_bit(input logic [N-1:0] s, input int idx);
        bit h[$];
        bit b;
        b = 1'b0;
        for (int i = N - 1; i >= 0; i--) h.push_back(s[i]);
        for (int k = 0; k <= idx; k++) begin
            b = h[0] ^ h[N - T];
            h.push_back(b);
            void'(h.pop_front());
        end
        return b;
    endfunction

    task automatic model_reset();
        model_seed('1);
        m_run = 0; m_k = 0; m_r = 0; m_count = 0; m_fixed = 0;
        m_armed = 0; m_errs = 0;
    endtask

    // Advance one clock, then compare all outputs against the model.
    task automatic cyc();
        bit exp_valid;
        bit eb;
        @(negedge clk);
        exp_valid = 0;
        eb = 0;
        if (m_run) begin
            if (stop) m_run = 0;
            else begin
                m_k++;
                exp_valid = (m_k % (m_r + 1)) == 0;
            end
        end else if (start) begin
            m_run = 1; m_k = 0; m_r = int'(rate_div); m_count = 0; m_fixed = 0; m_errs = 0;
        end else if (seed_load) begin
            model_seed(seed_in);
            if (seed_in == '0) m_fixed = 1;
        end
        if (exp_valid) begin
            eb = model_next() ^ m_armed;
            if (m_armed) begin m_errs++; m_armed = 0; end
            m_count++;
            obs.push_back(bit_out);
        end
        check("bit_valid", 32'(bit_valid), 32'(exp_valid));
        if (exp_valid) check("bit_out", 32'(bit_out), 32'(eb));
        check("busy", 32'(busy), 32'(m_run));
        check("bit_count", bit_count, 32'(m_count));
        check("seed_fixed", 32'(seed_fixed), 32'(m_fixed));
`ifdef PRBS_ERR_INJ_EN
        check("err_count", 32'(err_count), 32'(m_errs));
        if (err_inject) m_armed = 1;
`endif
    endtask

    task automatic do_start(input int r);
        rate_div = 16'(r);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bit_out"},    32'(bit_out), 32'd0);
        check({tag, "_bit_valid"},  32'(bit_valid), 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_bit_count"},  bit_count, 32'd0);
        check({tag, "_seed_fixed"}, 32'(seed_fixed), 32'd0);
`ifdef PRBS_ERR_INJ_EN
        check({tag, "_err_count"},  32'(err_count), 32'd0);
`endif
    endtask

    function automatic logic [7:0] first8();
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f = {f[6:0], obs[i]};
        return f;
    endfunction

    initial begin
        logic [N-1:0] s;
        int ones;
        int len;
        logic [31:0] cnt_snap;

        // ---- reset values
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) cyc();

        // ---- PRBS7 from reset seed, continuous rate
        obs.delete();
        do_start(0);
        repeat (127) cyc();
        check("count_one_period", bit_count, 32'd127);
        repeat (127) cyc();
        check("first8", 32'(first8()), 32'h02);
        ones = 0;
        for (int i = 0; i < 127; i++) ones += int'(obs[i]);
        check("ones_per_period", 32'(ones), 32'd64);
        for (int i = 0; i < 127; i++) begin
            if (obs[i] != obs[i + 127]) check("period_repeat", 32'(obs[i + 127]), 32'(obs[i]));
        end
        check("period_compared", 32'(obs.size()), 32'd254);
        do_stop();
        repeat (3) cyc();

        // ---- rate_div = 3: pulse every 4 cycles
        do_start(3);
        rate_div = 16'd9;       // must not affect the running interval
        repeat (40) cyc();
        check("count_10_pulses", bit_count, 32'd10);
        do_stop();

        // ---- zero seed is replaced by all ones
        seed_in = '0;
        seed_load = 1'b1;
        cyc();
        seed_load = 1'b0;
        check("seed_fixed_set", 32'(seed_fixed), 32'd1);
        obs.delete();
        do_start(0);
        check("seed_fixed_clr", 32'(seed_fixed), 32'd0);
        repeat (8) cyc();
        check("first8_after_zero_seed", 32'(first8()), 32'h02);
        do_stop();

        // ---- stop after 5 bits, resume; start+seed_load ignores seed
        s = N'($urandom);
        if (s == '0) s = 1;
        seed_in = s;
        seed_load = 1'b1;
        cyc();
        seed_load = 1'b0;
        obs.delete();
        do_start(0);
        repeat (5) cyc();
        do_stop();
        repeat (4) cyc();
        seed_in = ~s;
        seed_load = 1'b1;
        do_start(0);
        seed_load = 1'b0;
        repeat (6) cyc();
        check("resume_bit6", 32'(obs[5]), 32'(ref_bit(s, 5)));
        do_stop();

        // ---- randomized runs
        for (int it = 0; it < 4; it++) begin
            s = N'($urandom);
            seed_in = s;
            seed_load = 1'b1;
            cyc();
            seed_load = 1'b0;
            do_start(int'($urandom_range(4, 0)));
            len = int'($urandom_range(30, 10));
            for (int c = 0; c < len; c++) begin
`ifdef PRBS_ERR_INJ_EN
                err_inject = ($urandom_range(7, 0) == 0);
`endif
                cyc();
            end
`ifdef PRBS_ERR_INJ_EN
            err_inject = 1'b0;
`endif
            do_stop();
            repeat (2) cyc();
        end

`ifdef PRBS_ERR_INJ_EN
        // ---- error injection: pulse while bit 9 is emitted -> bit 10 inverted
        repeat (10) cyc();      // let any pending arm settle harmlessly in IDLE
        s = 7'h35;
        seed_in = s;
        seed_load = 1'b1;
        cyc();
        seed_load = 1'b0;
        obs.delete();
        m_armed = 0;
        // clear a possibly armed flag: one emission consumes it, then reseed
        do_start(0);
        cyc();
        do_stop();
        seed_load = 1'b1;
        cyc();
        seed_load = 1'b0;
        obs.delete();
        do_start(0);
        repeat (8) cyc();
        err_inject = 1'b1;
        cyc();
        err_inject = 1'b0;
        cyc();
        cyc();
        check("inj_bit10_inverted", 32'(obs[9]), 32'(~ref_bit(s, 9)));
        check("inj_bit11_clean", 32'(obs[10]), 32'(ref_bit(s, 10)));
        check("inj_err_count_1", 32'(err_count), 32'd1);
        do_stop();

        // ---- two pulses within one gap count once
        do_start(3);
        err_inject = 1'b1; cyc();
        err_inject = 1'b0; cyc();
        err_inject = 1'b1; cyc();
        err_inject = 1'b0;
        repeat (9) cyc();
        check("inj_double_pulse", 32'(err_count), 32'd1);
        do_stop();
`endif

        // ---- async reset mid-run, rate_div = 5
        do_start(5);
        repeat (7) cyc();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrun");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cnt_snap = bit_count;
        repeat (8) cyc();
        check("no_bits_after_reset", bit_count, cnt_snap);
        obs.delete();
        do_start(0);
        repeat (8) cyc();
        check("first8_after_reset", 32'(first8()), 32'h02);
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
